// File: rtl/dffnrsnq_pipe_pkg.sv
// rtl/dffnrsnq_pipe_pkg.sv - shared constants, op encoding and sizing helpers for the negedge pipeline
package dffnrsnq_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;

  // Per-edge operation, listed in decreasing priority.
  typedef enum logic [2:0] {
    OP_RESET   = 3'd0,
    OP_PRESET  = 3'd1,
    OP_SCAN    = 3'd2,
    OP_ADVANCE = 3'd3,
    OP_HOLD    = 3'd4
  } pipe_op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int scan_len(input int width, input int depth);
    return width * depth;
  endfunction

  localparam int DEF_SCAN_LEN = DEF_WIDTH * DEF_DEPTH;

endpackage

// File: rtl/dffnrsnq_pipe_stage.sv
// rtl/dffnrsnq_pipe_stage.sv - one WIDTH-bit negedge stage with valid; scan mux under DFFNRSNQ_PIPE_SCAN_EN
module dffnrsnq_pipe_stage
  import dffnrsnq_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             i_clkn,
  input  logic             i_rn,
  input  logic             i_setn,
  input  logic             i_ld,
  input  logic             i_se,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_v,
  input  logic             i_si,
  output logic [WIDTH-1:0] o_q,
  output logic             o_v,
  output logic             o_so
);

  logic [WIDTH-1:0] r_q;
  logic             r_v;

`ifdef DFFNRSNQ_PIPE_SCAN_EN
  // Scan moves toward the MSB; valid is not part of the chain and holds.
  logic [WIDTH-1:0] w_shift;
  assign w_shift = WIDTH'({r_q, i_si});

  always_ff @(negedge i_clkn) begin
    if (!i_rn) begin
      r_q <= '0;
      r_v <= 1'b0;
    end else if (!i_setn) begin
      r_q <= SET_VALUE;
      r_v <= 1'b1;
    end else if (i_se) begin
      r_q <= w_shift;
    end else if (i_ld) begin
      r_q <= i_d;
      r_v <= i_v;
    end
  end

  assign o_so = r_q[WIDTH-1];
`else
  logic w_unused_scan;
  assign w_unused_scan = ^{i_se, i_si};

  always_ff @(negedge i_clkn) begin
    if (!i_rn) begin
      r_q <= '0;
      r_v <= 1'b0;
    end else if (!i_setn) begin
      r_q <= SET_VALUE;
      r_v <= 1'b1;
    end else if (i_ld) begin
      r_q <= i_d;
      r_v <= i_v;
    end
  end

  assign o_so = 1'b0;
`endif

  assign o_q = r_q;
  assign o_v = r_v;

endmodule

// File: rtl/dffnrsnq_pipe.sv
// rtl/dffnrsnq_pipe.sv - WIDTH x DEPTH negedge pipeline with valid, stall, preset, COUNT; scan via DFFNRSNQ_PIPE_SCAN_EN
module dffnrsnq_pipe
  import dffnrsnq_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                      CLKN,
  input  logic                      RN,
  input  logic                      SETN,
  input  logic                      EN,
  input  logic [WIDTH-1:0]          D,
  input  logic                      VI,
  output logic [WIDTH-1:0]          Q,
  output logic                      VO,
  output logic [cnt_w(DEPTH)-1:0]   COUNT,
  input  logic                      SE,
  input  logic                      SI,
  output logic                      SO
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] w_q [DEPTH];
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_so;
  pipe_op_e         w_op;
  logic [CW-1:0]    r_count;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_d_in;
    logic             w_v_in;
    logic             w_si_in;

    if (g == 0) begin : g_head
      assign w_d_in  = D;
      assign w_v_in  = VI;
      assign w_si_in = SI;
    end else begin : g_body
      assign w_d_in  = w_q[g-1];
      assign w_v_in  = w_v[g-1];
      assign w_si_in = w_so[g-1];
    end

    dffnrsnq_pipe_stage #(
      .WIDTH     (WIDTH),
      .SET_VALUE (SET_VALUE)
    ) u_stage (
      .i_clkn (CLKN),
      .i_rn   (RN),
      .i_setn (SETN),
      .i_ld   (EN),
      .i_se   (SE),
      .i_d    (w_d_in),
      .i_v    (w_v_in),
      .i_si   (w_si_in),
      .o_q    (w_q[g]),
      .o_v    (w_v[g]),
      .o_so   (w_so[g])
    );
  end

  always_comb begin
    w_op = OP_HOLD;
    if (!RN) begin
      w_op = OP_RESET;
    end else if (!SETN) begin
      w_op = OP_PRESET;
`ifdef DFFNRSNQ_PIPE_SCAN_EN
    end else if (SE) begin
      w_op = OP_SCAN;
`endif
    end else if (EN) begin
      w_op = OP_ADVANCE;
    end
  end

  // Running count instead of a popcount: +1 per valid entering, -1 per valid leaving.
  always_ff @(negedge CLKN) begin
    case (w_op)
      OP_RESET:   r_count <= '0;
      OP_PRESET:  r_count <= CW'(DEPTH);
      OP_ADVANCE: r_count <= r_count + CW'(VI) - CW'(w_v[DEPTH-1]);
      default:    r_count <= r_count;
    endcase
  end

  assign Q     = w_q[DEPTH-1];
  assign VO    = w_v[DEPTH-1];
  assign COUNT = r_count;
  assign SO    = w_so[DEPTH-1];

endmodule

// File: doc/dffnrsnq_pipe.md
Name: dffnrsnq_pipe

Overview:
- Parametrised successor to the single-bit negative-edge set/reset flop: a WIDTH-bit, DEPTH-stage negative-edge pipeline register.
- Adds per-stage valid tracking, a stall enable, a synchronous preset to a programmable value, and an occupancy count.
- Optional serial scan chain for test access.
- Used in datapaths that capture on the falling clock edge, for example half-cycle retiming into positive-edge logic.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 3, number of pipeline stages (>=1)
- SET_VALUE, {WIDTH{1'b1}}, data value loaded into every stage by SETN

Ports:
- CLKN  input  1  clock; all state updates on the falling edge
- RN  input  1  synchronous active-low reset, sampled on the CLKN falling edge
- SETN  input  1  synchronous active-low preset, sampled on the CLKN falling edge
- EN  input  1  advance enable; 0 = stall (all stages hold)
- D  input  WIDTH  stage-0 data in
- VI  input  1  stage-0 valid in
- Q  output  WIDTH  last-stage data, driven directly from flops
- VO  output  1  last-stage valid
- COUNT  output  $clog2(DEPTH+1)  number of stages holding valid=1
- SE  input  1  scan enable (active only with DFFNRSNQ_PIPE_SCAN_EN)
- SI  input  1  scan in
- SO  output  1  scan out

Behaviour:
- Clocking and reset: one clock, CLKN, falling edge. Reset is synchronous and active-low on RN. No asynchronous paths.
- Priority per falling edge: RN > SETN > SE (scan) > EN > hold.
- RN=0:
  - all stage data = 0, all valid = 0, COUNT = 0
  - Q = 0, VO = 0, SO = 0 after the edge
- RN=1, SETN=0:
  - all stage data = SET_VALUE, all valid = 1, COUNT = DEPTH
  - RN=0 and SETN=0 together: reset wins.
- Advance (EN=1, SE=0 or scan compiled out):
  - stage0 <= {D, VI}; stage i <= stage i-1 for i = 1..DEPTH-1
  - Latency D->Q = DEPTH falling edges.
  - DEPTH=1 is a single register: Q follows D after one edge.
- Hold (EN=0): data, valid and COUNT all hold. D and VI are ignored.
- Data in stages with valid=0 still shifts. The block never gates data on valid.
- COUNT is a registered counter, not a popcount:
  - next = COUNT + VI - VO_current on an advance edge
  - unchanged on hold
  - VI=1 with VO=1 leaves it unchanged
  - must always equal the popcount of the valid bits
  - never wraps: 0..DEPTH
- Reset or preset mid-stream discards all in-flight data with no drain.
- Outputs are registered only; there is no combinational D->Q path.

Optional Feature:
- Macro: DFFNRSNQ_PIPE_SCAN_EN
- Defined: SE=1 (with RN=1, SETN=1) shifts the data bits serially on each falling edge, regardless of EN.
  - Chain order: SI -> stage0[0] -> stage0[WIDTH-1] -> stage1[0] -> ... -> stage(DEPTH-1)[WIDTH-1] -> SO.
  - SO = stage(DEPTH-1)[WIDTH-1], driven from the flop.
  - Valid bits and COUNT hold during scan; they are not in the chain.
  - Chain length = WIDTH*DEPTH.
- Undefined: SE and SI are ignored, SO is tied 0, and no scan mux is inferred.

Decomposition:
- Package dffnrsnq_pipe_pkg holds:
  - default WIDTH/DEPTH constants
  - function cnt_w(depth) returning $clog2(depth+1)
  - scan chain length constant expression
- Sub-module dffnrsnq_pipe_stage: one WIDTH-bit stage plus valid, with a synchronous RN/SETN priority mux, load enable and scan-in mux.
- Top instantiates DEPTH stages in a generate loop and owns COUNT.

Test Plan:
- Reset: RN=0 for 2 falling edges with random D/VI -> Q=0, VO=0, COUNT=0, SO=0. Release RN, EN=0 for 3 edges -> outputs unchanged.
- Stream (WIDTH=8, DEPTH=3): EN=1, apply D=0x11,0x22,0x33,0x44 with VI=1 on consecutive edges -> Q=0x11 after edge 3, 0x22 after edge 4. COUNT goes 1,2,3,3.
- Stall and bubble: after stream, EN=0 for 2 edges -> Q/COUNT frozen. Then EN=1 with VI=0 ×3 -> VO drops in order and COUNT goes 2,1,0.
- Preset vs reset: SETN=0 alone -> Q=0xFF, VO=1, COUNT=3. SETN=0 with RN=0 on the same edge -> Q=0, COUNT=0.
- DEPTH=1, WIDTH=1 build: D=1, VI=1, EN=1 -> Q=1, VO=1, COUNT=1 after one edge. A simultaneous VI=0 advance gives COUNT=0.
- Scan (macro defined, WIDTH=8, DEPTH=3): SE=1, shift in 24 bits of pattern 0xA5C33C LSB-first -> the pattern re-emerges on SO on the following 24 edges. VO/COUNT unchanged throughout. Without the macro, SO stays 0 and SE=1 with EN=1 advances normally.
